// File: rtl/serdes_pkg.sv
// Shared constants and types for the serializer TX word scheduler.
//   WORD_W    : serializer parallel word width
//   SLOT_LEN  : serial-rate cycles per word slot (shared with the 10:1 serializer)
//   COMMA_P/N : link-training comma words (both disparities)
//   IDLE_WORD : filler word sent when no requester is pending
package serdes_pkg;

  localparam int unsigned WORD_W   = 10;
  localparam int unsigned SLOT_LEN = 10;

  localparam logic [WORD_W-1:0] COMMA_P   = 10'b0011111010;
  localparam logic [WORD_W-1:0] COMMA_N   = 10'b1100000101;
  localparam logic [WORD_W-1:0] IDLE_WORD = 10'b1001110100;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/serdes_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1
//   grant : one-hot winner (zero when no request)
//   index : binary winner index
//   any   : at least one request present
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  int unsigned pos;

  // Walk last+1 .. last+N modulo N; first asserted request wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (32'(last) + k) % N;
      if (!any && req[IW'(pos)]) begin
        any               = 1'b1;
        index             = IW'(pos);
        grant[IW'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_sched.sv
// Word-slot scheduler feeding a 10:1 serializer: link-training comma burst,
// then round-robin sharing of word slots between N_REQ requesters, idle fill.
//   clk, rst_n  : serial-rate clock, async active-low reset
//   enable      : global run; low freezes slot counter, FSM, pointer, outputs
//   train_req   : level request for a retrain at the next slot boundary
//   req/req_data: per-requester word request and 10-bit word (slice i)
//   gnt         : one-cycle one-hot grant in the first cycle of the slot
//   ser_data    : serializer word, stable for a full slot
//   ser_enable  : enable delayed one cycle, keeps serializer phase-aligned
//   slot_start  : pulse in the first cycle of each slot
//   link_up     : state is ACTIVE
//   training    : state is TRAIN
module serdes_tx_sched
  import serdes_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TRAIN_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      train_req,
  input  logic [N_REQ-1:0]          req,
  input  logic [WORD_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [WORD_W-1:0]         ser_data,
  output logic                      ser_enable,
  output logic                      slot_start,
  output logic                      link_up,
  output logic                      training
);

  localparam int unsigned IW    = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(SLOT_LEN);
  localparam int unsigned TC_W  = $clog2(TRAIN_WORDS);

  logic [CNT_W-1:0]  slot_cnt;
  logic              boundary;
  tx_state_e         state, state_nxt;
  logic [TC_W-1:0]   train_cnt, train_cnt_nxt;
  logic [IW-1:0]     rr_last, rr_last_nxt;
  logic              arb_load;
  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [WORD_W-1:0] ser_data_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [WORD_W-1:0] word_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign word_arr[i] = req_data[WORD_W*i +: WORD_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req),
    .last  (rr_last),
    .grant (arb_grant),
    .index (arb_idx),
    .any   (arb_any)
  );

  // Last enabled cycle of a slot; all scheduling happens on this edge.
  assign boundary = enable && (slot_cnt == CNT_W'(SLOT_LEN - 1));

  // Mod-SLOT_LEN slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (enable) begin
      slot_cnt <= boundary ? '0 : slot_cnt + CNT_W'(1);
    end
  end

  // State register: FSM, training word count, round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TRAIN;
      train_cnt <= '0;
      rr_last   <= IW'(N_REQ - 1);
    end else if (boundary) begin
      state     <= state_nxt;
      train_cnt <= train_cnt_nxt;
      rr_last   <= rr_last_nxt;
    end
  end

  // Next-state logic; arb_load marks a boundary whose slot is arbitrated.
  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    rr_last_nxt   = rr_last;
    arb_load      = 1'b0;
    unique case (state)
      TRAIN: begin
        if (train_cnt == TC_W'(TRAIN_WORDS - 1)) begin
          state_nxt     = ACTIVE;
          train_cnt_nxt = '0;
          arb_load      = 1'b1;
        end else begin
          train_cnt_nxt = train_cnt + TC_W'(1);
        end
      end
      ACTIVE: begin
        if (train_req) begin
          state_nxt     = TRAIN;
          train_cnt_nxt = '0;
        end else begin
          arb_load = 1'b1;
        end
      end
    endcase
    if (arb_load && arb_any) begin
      rr_last_nxt = arb_idx;
    end
  end

  // Word and grant to load at the boundary.
  always_comb begin
    ser_data_nxt = ser_data;
    gnt_nxt      = '0;
    if (arb_load) begin
      if (arb_any) begin
        ser_data_nxt = word_arr[arb_idx];
        gnt_nxt      = arb_grant;
      end else begin
        ser_data_nxt = IDLE_WORD;
      end
    end else if (state == TRAIN) begin
      // Next word index is train_cnt+1, so odd current count means even next.
      ser_data_nxt = train_cnt[0] ? COMMA_P : COMMA_N;
    end else begin
      ser_data_nxt = COMMA_P;
    end
  end

  // Output registers; pulses clear on any edge that is not a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_data   <= COMMA_P;
      gnt        <= '0;
      slot_start <= 1'b0;
      ser_enable <= 1'b0;
      link_up    <= 1'b0;
      training   <= 1'b1;
    end else begin
      ser_enable <= enable;
      slot_start <= boundary;
      gnt        <= boundary ? gnt_nxt : '0;
      if (boundary) begin
        ser_data <= ser_data_nxt;
        link_up  <= (state_nxt == ACTIVE);
        training <= (state_nxt == TRAIN);
      end
    end
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Directed self-checking bench for serdes_tx_sched (N_REQ=4, TRAIN_WORDS=16).
module tb_serdes_tx_sched;

  localparam logic [9:0] CP   = 10'b0011111010;
  localparam logic [9:0] CN   = 10'b1100000101;
  localparam logic [9:0] IDLE = 10'b1001110100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        train_req;
  logic [3:0]  req;
  logic [39:0] req_data;
  logic [3:0]  gnt;
  logic [9:0]  ser_data;
  logic        ser_enable;
  logic        slot_start;
  logic        link_up;
  logic        training;
  logic [9:0]  rd [4];

  int checks = 0;
  int errors = 0;

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  always #5 clk = ~clk;

  serdes_tx_sched #(.N_REQ(4), .TRAIN_WORDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .train_req  (train_req),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .ser_data   (ser_data),
    .ser_enable (ser_enable),
    .slot_start (slot_start),
    .link_up    (link_up),
    .training   (training)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Align to the first cycle of a slot, bounded.
  task automatic wait_slot(input string tag);
    for (int i = 0; i < 20 && !slot_start; i++) @(negedge clk);
    if (!slot_start) chk({tag, "_timeout"}, 32'(slot_start), 32'd1);
  endtask

  // Called in the first cycle of a slot; checks the whole slot, returns at the next slot start.
  task automatic hold_slot(input string tag, input logic [9:0] exp_data,
                           input logic [3:0] exp_gnt, input logic exp_link);
    chk({tag, "_link"}, 32'(link_up), 32'(exp_link));
    chk({tag, "_train"}, 32'(training), 32'(!exp_link));
    for (int i = 0; i < 10; i++) begin
      chk({tag, "_data"}, 32'(ser_data), 32'(exp_data));
      chk({tag, "_gnt"}, 32'(gnt), (i == 0) ? 32'(exp_gnt) : 32'd0);
      chk({tag, "_sstart"}, 32'(slot_start), (i == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(ser_data), 32'(CP));
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_sstart"}, 32'(slot_start), 32'd0);
    chk({tag, "_sen"}, 32'(ser_enable), 32'd0);
    chk({tag, "_link"}, 32'(link_up), 32'd0);
    chk({tag, "_train"}, 32'(training), 32'd1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    enable    = 1'b1;
    train_req = 1'b0;
    req       = 4'd0;
    for (int i = 0; i < 4; i++) rd[i] = 10'd0;

    // Reset state and full training burst from reset.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("slot0_data", 32'(ser_data), 32'(CP));
    chk("slot0_sen", 32'(ser_enable), 32'd1);
    wait_slot("boot");
    for (int k = 1; k < 16; k++)
      hold_slot($sformatf("boot_train%0d", k), k[0] ? CN : CP, 4'd0, 1'b0);
    hold_slot("idle16", IDLE, 4'd0, 1'b1);

    // All four requesters held: round-robin 0,1,2,3,0,1.
    req = 4'hF;
    rd[0] = 10'h101; rd[1] = 10'h202; rd[2] = 10'h303; rd[3] = 10'h004;
    hold_slot("idle17", IDLE, 4'd0, 1'b1);
    hold_slot("rr0", 10'h101, 4'b0001, 1'b1);
    hold_slot("rr1", 10'h202, 4'b0010, 1'b1);
    hold_slot("rr2", 10'h303, 4'b0100, 1'b1);
    hold_slot("rr3", 10'h004, 4'b1000, 1'b1);
    hold_slot("rr4", 10'h101, 4'b0001, 1'b1);
    req = 4'd0;
    hold_slot("rr5", 10'h202, 4'b0010, 1'b1);

    // req[2] raised mid-slot is not served until the next boundary.
    for (int i = 0; i < 10; i++) begin
      chk("mid_data", 32'(ser_data), 32'(IDLE));
      chk("mid_gnt", 32'(gnt), 32'd0);
      if (i == 3) begin
        req[2] = 1'b1;
        rd[2]  = 10'h155;
      end
      @(negedge clk);
    end
    wait_slot("mid");
    // Drop req[2]; raise train_req together with req[1] for the next boundary.
    req       = 4'b0010;
    rd[1]     = 10'h0AA;
    train_req = 1'b1;
    hold_slot("mid_gnt2", 10'h155, 4'b0100, 1'b1);

    // Retrain has priority; req[1] stays pending through the burst.
    train_req = 1'b0;
    for (int k = 0; k < 16; k++)
      hold_slot($sformatf("re_train%0d", k), k[0] ? CN : CP, 4'd0, 1'b0);
    req   = 4'b1000;
    rd[3] = 10'h3C3;
    hold_slot("re_gnt1", 10'h0AA, 4'b0010, 1'b1);

    // Freeze at slot_cnt 5 for 7 cycles inside the 0x3C3 slot.
    req   = 4'b0001;
    rd[0] = 10'h111;
    for (int i = 0; i < 5; i++) begin
      chk("frz_pre_data", 32'(ser_data), 32'(10'h3C3));
      chk("frz_pre_gnt", 32'(gnt), (i == 0) ? 32'd8 : 32'd0);
      @(negedge clk);
    end
    enable = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("frz_sen", 32'(ser_enable), 32'd0);
      chk("frz_data", 32'(ser_data), 32'(10'h3C3));
      chk("frz_sstart", 32'(slot_start), 32'd0);
    end
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && !slot_start; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("frz_sen_on", 32'(ser_enable), 32'd1);
      if (!slot_start) chk("frz_post_data", 32'(ser_data), 32'(10'h3C3));
    end
    chk("frz_remaining", 32'(n), 32'd5);
    req = 4'd0;
    hold_slot("frz_next", 10'h111, 4'b0001, 1'b1);

    // Async reset at slot_cnt 6 in ACTIVE; pointer returns to favour requester 0.
    req   = 4'b0011;
    rd[0] = 10'h2F0;
    rd[1] = 10'h0F2;
    for (int i = 0; i < 6; i++) begin
      chk("pre_rst_data", 32'(ser_data), 32'(IDLE));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_slot0_data", 32'(ser_data), 32'(CP));
    chk("rst_slot0_train", 32'(training), 32'd1);
    wait_slot("rst_boot");
    for (int k = 1; k < 16; k++)
      hold_slot($sformatf("rst_train%0d", k), k[0] ? CN : CP, 4'd0, 1'b0);
    req = 4'd0;
    hold_slot("rst_first_gnt", 10'h2F0, 4'b0001, 1'b1);
    hold_slot("rst_idle", IDLE, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
